// File: rtl/expr_unpack_pkg.sv
// Shared definitions for the expression-result unpacker: bus geometry,
// per-field slice helpers and the FSM state type.
package expr_unpack_pkg;

    localparam int NFIELDS  = 18;
    localparam int PACKED_W = 90;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EMIT
    } state_t;

    // Fields come in groups of three (4, 5 and 6 bits wide) packed into 15-bit slots.
    function automatic logic [6:0] f_msb(input logic [4:0] i);
        int t;
        int j;
        int off;
        t   = int'(i) / 3;
        j   = int'(i) % 3;
        off = (j == 0) ? 0 : ((j == 1) ? 4 : 9);
        return 7'(PACKED_W - 1 - 15 * t - off);
    endfunction

    function automatic logic [2:0] f_width(input logic [4:0] i);
        return 3'(4 + int'(i) % 3);
    endfunction

    // Every second group of three fields is signed.
    function automatic logic f_signed(input logic [4:0] i);
        return (int'(i) % 6) >= 3;
    endfunction

endpackage

// File: rtl/expr_unpack_fifo.sv
// Small count-based FIFO holding whole packed result words.
module expr_unpack_fifo
    import expr_unpack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push_valid_i,
    output logic                push_ready_o,
    input  logic [PACKED_W-1:0] push_data_i,
    input  logic                pop_i,
    output logic                empty_o,
    output logic [PACKED_W-1:0] head_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [PACKED_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                push;
    logic                pop;

    assign push_ready_o = (count_q != CW'(DEPTH));
    assign empty_o      = (count_q == '0);
    assign head_o       = mem_q[rd_ptr_q];
    assign push         = push_valid_i && push_ready_o;
    assign pop          = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the empty count keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/expr_result_unpacker.sv
// Streams each buffered 90-bit result word out as 18 sign-/zero-extended field beats.
// Define EXPR_UNPACK_CSUM_EN to append a 19th XOR-checksum beat to every word.
module expr_result_unpacker
    import expr_unpack_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int OUT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PACKED_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          field_idx,
    output logic [OUT_W-1:0]    field_val,
    output logic                field_last
);

`ifdef EXPR_UNPACK_CSUM_EN
    localparam logic CSUM_EN = 1'b1;
`else
    localparam logic CSUM_EN = 1'b0;
`endif

    localparam logic [4:0] LAST_IDX = CSUM_EN ? 5'(NFIELDS) : 5'(NFIELDS - 1);

    // The 6-bit window below a field's msb always covers the field, and its
    // top bit is the field's sign bit regardless of the field width.
    function automatic logic [OUT_W-1:0] f_extract(input logic [PACKED_W-1:0] word,
                                                   input logic [4:0]          i);
        logic [5:0]       win;
        logic [2:0]       w;
        logic [OUT_W-1:0] res;
        win = word[f_msb(i) -: 6];
        w   = f_width(i);
        res = OUT_W'(win >> (3'd6 - w));
        if (f_signed(i) && win[5]) begin
            res = res | ({OUT_W{1'b1}} << w);
        end
        return res;
    endfunction

    state_t               state_q, state_d;
    logic [PACKED_W-1:0]  shadow_q, shadow_d;
    logic [4:0]           idx_q, idx_d;
    logic [OUT_W-1:0]     val_q, val_d;
    logic                 last_q, last_d;
    logic                 valid_q, valid_d;
    logic [OUT_W-1:0]     csum_q, csum_d;
    logic [4:0]           nidx;
    logic [OUT_W-1:0]     nval;
    logic                 fifo_pop;
    logic                 fifo_empty;
    logic [PACKED_W-1:0]  fifo_head;

    expr_unpack_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (in_valid),
        .push_ready_o (in_ready),
        .push_data_i  (in_data),
        .pop_i        (fifo_pop),
        .empty_o      (fifo_empty),
        .head_o       (fifo_head)
    );

    assign out_valid  = valid_q;
    assign field_idx  = idx_q;
    assign field_val  = val_q;
    assign field_last = last_q;

    // Next-state logic: load a word, then walk its fields while the consumer accepts.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        val_d    = val_q;
        last_d   = last_q;
        valid_d  = valid_q;
        csum_d   = csum_q;
        fifo_pop = 1'b0;
        nidx     = idx_q + 5'd1;
        nval     = '0;
        unique case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (!fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                fifo_pop = 1'b1;
                shadow_d = fifo_head;
                idx_d    = '0;
                nval     = f_extract(fifo_head, 5'd0);
                val_d    = nval;
                csum_d   = nval;
                last_d   = 1'b0;
                valid_d  = 1'b1;
                state_d  = EMIT;
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_q) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = fifo_empty ? IDLE : LOAD;
                    end else begin
                        idx_d  = nidx;
                        last_d = (nidx == LAST_IDX);
                        if (CSUM_EN && (nidx == 5'(NFIELDS))) begin
                            val_d = csum_q;
                        end else begin
                            nval   = f_extract(shadow_q, nidx);
                            val_d  = nval;
                            csum_d = csum_q ^ nval;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered output beat; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            val_q    <= '0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            csum_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            csum_q   <= csum_d;
        end
    end

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Scoreboard bench for expr_result_unpacker; follows EXPR_UNPACK_CSUM_EN if defined.
module tb_expr_result_unpacker;

    localparam int OUT_W = 8;
    localparam int DEPTH = 2;
`ifdef EXPR_UNPACK_CSUM_EN
    localparam bit CSUM  = 1'b1;
    localparam int BEATS = 19;
`else
    localparam bit CSUM  = 1'b0;
    localparam int BEATS = 18;
`endif

    typedef struct {
        logic [4:0] idx;
        logic [7:0] val;
        logic       last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [89:0]      in_data = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [4:0]       field_idx;
    logic [OUT_W-1:0] field_val;
    logic             field_last;

    int    errors = 0;
    int    checks = 0;
    int    beatCount = 0;
    int    readyMode = 0;
    bit    stalled = 1'b0;
    beat_t held;
    beat_t sbQ[$];
    logic [7:0] obsVal [19];

    expr_result_unpacker #(
        .DEPTH (DEPTH),
        .OUT_W (OUT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .field_idx  (field_idx),
        .field_val  (field_val),
        .field_last (field_last)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference slicer: field i sits in 15-bit slot i/3 at offset {0,4,9}, width 4+i%3.
    function automatic logic [7:0] refField(input logic [89:0] word, input int i);
        int offs[3];
        int t, j, w, msb, lsb, val;
        logic [89:0] sh;
        offs = '{0, 4, 9};
        t    = i / 3;
        j    = i % 3;
        w    = 4 + j;
        msb  = 89 - 15 * t - offs[j];
        lsb  = msb - w + 1;
        sh   = word >> lsb;
        val  = int'(sh[5:0]) & ((1 << w) - 1);
        if ((i % 6) >= 3 && val >= (1 << (w - 1))) begin
            val = val - (1 << w);
        end
        return val[7:0];
    endfunction

    task automatic modelPush(input logic [89:0] word);
        logic [7:0] v;
        logic [7:0] cs;
        cs = '0;
        for (int i = 0; i < 18; i++) begin
            v = refField(word, i);
            sbQ.push_back('{5'(i), v, 1'(!CSUM && i == 17)});
            cs = cs ^ v;
        end
        if (CSUM) begin
            sbQ.push_back('{5'd18, cs, 1'b1});
        end
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = stalled, 2 = random.
    always @(posedge clk) begin
        #1;
        case (readyMode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: records accepted words into the scoreboard and checks every beat.
    always @(negedge clk) begin
        beat_t exp;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                modelPush(in_data);
            end
            if (stalled) begin
                checkOutput("stall_valid", 32'(out_valid), 32'd1);
                if (out_valid) begin
                    checkOutput("stall_idx", 32'(field_idx), 32'(held.idx));
                    checkOutput("stall_val", 32'(field_val), 32'(held.val));
                    checkOutput("stall_last", 32'(field_last), 32'(held.last));
                end
            end
            if (out_valid) begin
                if (out_ready) begin
                    beatCount++;
                    if (sbQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got idx %0d, expected no beat", field_idx);
                    end else begin
                        exp = sbQ.pop_front();
                        checkOutput("beat_idx", 32'(field_idx), 32'(exp.idx));
                        checkOutput("beat_val", 32'(field_val), 32'(exp.val));
                        checkOutput("beat_last", 32'(field_last), 32'(exp.last));
                        obsVal[field_idx] = field_val;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = '{field_idx, field_val, field_last};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Present one word and hold it until the FIFO accepts it.
    task automatic applyStimulus(input logic [89:0] word);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = word;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_timeout: got in_ready 0, expected 1");
        end
    endtask

    task automatic waitDrain(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            if (sbQ.size() == 0) begin
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d pending beats, expected 0", sbQ.size());
        end
    endtask

    initial begin
        int lat;
        bit seen;
        logic [89:0] w;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_field_idx", 32'(field_idx), 32'd0);
        checkOutput("rst_field_val", 32'(field_val), 32'd0);
        checkOutput("rst_field_last", 32'(field_last), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Negative 6-bit y17 only, plus first-beat latency
        $display("[TB] y17 sign extension and latency");
        applyStimulus(90'h20);
        lat  = 0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) begin
                seen = 1'b1;
            end
        end
        checkOutput("latency", 32'(lat), 32'd2);
        waitDrain(100);
        checkOutput("y17_val", 32'(obsVal[17]), 32'hE0);
        checkOutput("y16_val", 32'(obsVal[16]), 32'h00);
        if (CSUM) begin
            checkOutput("y17_csum", 32'(obsVal[18]), 32'hE0);
        end

        // Unsigned versus signed 6-bit all-ones fields
        $display("[TB] y2 unsigned / y5 signed");
        applyStimulus((90'h3F << 75) | (90'h3F << 60));
        waitDrain(100);
        checkOutput("y2_val", 32'(obsVal[2]), 32'h3F);
        checkOutput("y5_val", 32'(obsVal[5]), 32'hFF);

        // All-ones word
        $display("[TB] all-ones word");
        applyStimulus({90{1'b1}});
        waitDrain(100);
        checkOutput("ones_y0", 32'(obsVal[0]), 32'h0F);
        checkOutput("ones_y1", 32'(obsVal[1]), 32'h1F);
        checkOutput("ones_y2", 32'(obsVal[2]), 32'h3F);
        checkOutput("ones_y3", 32'(obsVal[3]), 32'hFF);
        checkOutput("ones_y4", 32'(obsVal[4]), 32'hFF);
        checkOutput("ones_y5", 32'(obsVal[5]), 32'hFF);
        if (CSUM) begin
            checkOutput("ones_csum", 32'(obsVal[18]), 32'hD0);
        end

        // Reset while beat 7 is on the output
        $display("[TB] reset mid-word");
        applyStimulus(90'({$urandom, $urandom, $urandom}));
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (out_valid && field_idx == 5'd7) begin
                seen = 1'b1;
            end
        end
        checkOutput("reach_beat7", 32'(seen), 32'd1);
        #1;
        rst_n = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midrst_field_idx", 32'(field_idx), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(90'({$urandom, $urandom, $urandom}));
        waitDrain(100);

        // Back-to-back words with downstream stalled
        $display("[TB] FIFO fill with stalled output");
        readyMode = 1;
        repeat (2) @(posedge clk);
        #1;
        beatCount = 0;
        applyStimulus(90'({$urandom, $urandom, $urandom}));
        applyStimulus(90'({$urandom, $urandom, $urandom}));
        w        = 90'({$urandom, $urandom, $urandom});
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        checkOutput("full_in_ready", 32'(in_ready), 32'd0);
        applyStimulus(w);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("stalled_in_ready", 32'(in_ready), 32'd0);
        readyMode = 0;
        waitDrain(400);
        checkOutput("three_word_beats", 32'(beatCount), 32'(3 * BEATS));

        // Random words under random downstream stalls
        $display("[TB] random stalls");
        readyMode = 2;
        for (int n = 0; n < 8; n++) begin
            applyStimulus(90'({$urandom, $urandom, $urandom}));
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        waitDrain(2000);
        readyMode = 0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_idle", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
